// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// the operands LSB-first, one bit per clock, behind valid/ready handshakes.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic             s_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] sum_shift;

    // Full-adder cell on the current LSBs and the running carry.
    always_comb begin
        s_bit = a_q[0] ^ b_q[0] ^ c_q;
        c_nxt = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        sum_shift = sum_q >> 1;
        sum_shift[WIDTH-1] = s_bit;
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        in_ready    = (state_q == StIdle);
        out_valid   = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction as a + ~b + 1; carry_in is ignored then.
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? 1'b1 : carry_in;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_nxt;
                sum_d = sum_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    // c_q is the carry into the MSB here.
                    overflow_d  = c_q ^ c_nxt;
                    carry_out_d = c_nxt;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, sum;
    logic       carry_in, sub, carry_out, overflow;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // WIDTH=1 instance
    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0] a1, b1, sum1;
    logic       carry_in1, sub1, carry_out1, overflow1;

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .carry_in  (carry_in1),
        .sub       (sub1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .carry_out (carry_out1),
        .overflow  (overflow1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       co;
        logic       ov;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full WIDTH=8 transaction: accept, measure latency, check result, drain.
    task automatic run8(input vec_t v, input string name);
        int n;
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        a = v.a; b = v.b; carry_in = v.cin; sub = v.sub; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // Scramble inputs after acceptance; they must be ignored.
        a = ~v.a; b = ~v.b; carry_in = ~v.cin; sub = ~v.sub;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check({name, "_lat"}, 32'(n), 32'd8);
        check({name, "_sum"}, 32'(sum), 32'(v.sum));
        check({name, "_co"}, 32'(carry_out), 32'(v.co));
        check({name, "_ov"}, 32'(overflow), 32'(v.ov));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[10];
    logic [7:0] held;

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
        vecs[7] = '{8'h07, 8'h07, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[9] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; carry_in1 = 1'b0; sub1 = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_co", 32'(carry_out), 32'd0);
        check("rst_ov", 32'(overflow), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run8(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held while out_ready=0 and inputs toggle.
        a = 8'h3C; b = 8'h42; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) step();
        check("bp_valid", 32'(out_valid), 32'd1);
        held = sum;
        check("bp_sum0", 32'(held), 32'h7E);
        for (int i = 0; i < 5; i++) begin
            a = 8'(i * 37); b = ~a; in_valid = 1'b1;
            step();
            check("bp_sum", 32'(sum), 32'h7E);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_rel_ready", 32'(in_ready), 32'd1);
        check("bp_rel_valid", 32'(out_valid), 32'd0);
        check("bp_rel_sum", 32'(sum), 32'h7E);

        // Reset in the middle of RUN.
        a = 8'h21; b = 8'h13; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_sum", 32'(sum), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (out_valid) seen++;
            end
            check("mr_no_emit", 32'(seen), 32'd0);
        end
        run8('{8'h21, 8'h13, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0}, "mr_after");

        // WIDTH=1 full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            logic       es, ec;
            int         n;
            abc = 3'(i);
            es = abc[2] ^ abc[1] ^ abc[0];
            ec = (abc[2] & abc[1]) | (abc[0] & (abc[2] ^ abc[1]));
            a1 = abc[2]; b1 = abc[1]; carry_in1 = abc[0]; sub1 = 1'b0; in_valid1 = 1'b1;
            step();
            in_valid1 = 1'b0;
            n = 0;
            while (!out_valid1 && n < 10) begin
                step();
                n++;
            end
            check($sformatf("w1_lat%0d", i), 32'(n), 32'd1);
            check($sformatf("w1_sum%0d", i), 32'(sum1), 32'(es));
            check($sformatf("w1_co%0d", i), 32'(carry_out1), 32'(ec));
            check($sformatf("w1_ov%0d", i), 32'(overflow1), 32'(abc[0] ^ ec));
            out_ready1 = 1'b1;
            step();
            out_ready1 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
